// File: rtl/ring_johnson_counter.sv
// WIDTH-bit ring / Johnson shift counter with direction, prescaled stepping, parallel load,
// a wrap pulse and an illegal-pattern flag. Optional self-correction: RING_SELF_CORRECT_EN.
module ring_johnson_counter #(
  parameter int WIDTH    = 4,
  parameter int STEP_DIV = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_mode,
  input  logic             i_dir,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_out,
  output logic             o_wrap,
  output logic             o_err
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  logic [WIDTH-1:0] r_out;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_mode_q;
  logic             r_wrap;

  logic [WIDTH-1:0] w_home_mode;
  logic [WIDTH-1:0] w_home_q;
  logic             w_step;
  logic             w_fb_right;
  logic             w_fb_left;
  logic [WIDTH-1:0] w_next;
  logic             w_ring_ok;
  logic [WIDTH-2:0] w_edges;
  logic             w_john_ok;

  assign w_home_mode = i_mode   ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
  assign w_home_q    = r_mode_q ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
  assign w_step      = i_en && (r_div_cnt == DIV_LAST);

  // Johnson differs from ring only by inverting the bit that wraps around the end.
  assign w_fb_right = r_out[0] ^ r_mode_q;
  assign w_fb_left  = r_out[WIDTH-1] ^ r_mode_q;
  assign w_next     = i_dir ? {r_out[WIDTH-2:0], w_fb_left} : {w_fb_right, r_out[WIDTH-1:1]};

  assign w_ring_ok = (r_out != '0) && ((r_out & (r_out - WIDTH'(1))) == '0);
  // A legal Johnson pattern is a thermometer code: at most one 0/1 boundary between neighbours.
  assign w_edges   = r_out[WIDTH-1:1] ^ r_out[WIDTH-2:0];
  assign w_john_ok = ((w_edges & (w_edges - (WIDTH-1)'(1))) == '0);
  assign o_err     = r_mode_q ? !w_john_ok : !w_ring_ok;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out     <= w_home_mode;
      r_div_cnt <= '0;
      r_mode_q  <= i_mode;
      r_wrap    <= 1'b0;
    end else if (i_load) begin
      r_out     <= i_load_val;
      r_div_cnt <= '0;
      r_wrap    <= 1'b0;
    end else if (i_mode != r_mode_q) begin
      r_out     <= w_home_mode;
      r_mode_q  <= i_mode;
      r_div_cnt <= '0;
      r_wrap    <= 1'b0;
`ifdef RING_SELF_CORRECT_EN
    end else if (o_err) begin
      r_out     <= w_home_q;
      r_div_cnt <= '0;
      r_wrap    <= 1'b0;
`endif
    end else if (i_en) begin
      if (w_step) begin
        r_div_cnt <= '0;
        r_out     <= w_next;
        r_wrap    <= (w_next == w_home_q);
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
        r_wrap    <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign o_out  = r_out;
  assign o_wrap = r_wrap;

endmodule
